// File: rtl/serial_tx_scheduler_if.sv
// rtl/serial_tx_scheduler_if.sv - requester and transmitter signals of the serial tx scheduler
interface serial_tx_scheduler_if #(
  parameter int N = 2
) ();
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   done;
  logic [7:0]     tx_data;
  logic           tx_load;
  logic           tx_enable;
  logic           tx_sent;
  logic           busy;
  logic           timeout;

  modport master (
    output req, req_data, tx_sent,
    input  ack, done, tx_data, tx_load, tx_enable, busy, timeout
  );

  modport slave (
    input  req, req_data, tx_sent,
    output ack, done, tx_data, tx_load, tx_enable, busy, timeout
  );
endinterface

// File: rtl/serial_tx_scheduler.sv
// rtl/serial_tx_scheduler.sv - round-robin scheduler sharing one serial transmitter between N requesters
// Optional WAIT-state watchdog enabled by defining TX_TIMEOUT_EN.
module serial_tx_scheduler #(
  parameter int N              = 2,
  parameter int LOAD_CYCLES    = 512,
  parameter int GAP_CYCLES     = 256,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  serial_tx_scheduler_if.slave  bus
);
  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int MAXLG = (LOAD_CYCLES > GAP_CYCLES) ? LOAD_CYCLES : GAP_CYCLES;
  localparam int MAXC  = (MAXLG > TIMEOUT_CYCLES) ? MAXLG : TIMEOUT_CYCLES;
  localparam int CW    = (MAXC + 1 <= 2) ? 1 : $clog2(MAXC + 1);
  localparam int GAPLD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   g_q, g_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [N-1:0]    done_q, done_d;
  logic            tx_load_q, tx_load_d;
  logic            tx_enable_q, tx_enable_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic            tx_sent_q;
  logic            sent_edge;
  logic            any_req;
  logic [PW-1:0]   win;
  logic [PW-1:0]   next_g;

  assign sent_edge = bus.tx_sent & ~tx_sent_q;
  assign next_g    = (int'(g_q) == N - 1) ? '0 : g_q + 1'b1;

  // Walk from the highest offset down so the candidate closest to ptr wins.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (bus.req[idx]) begin
        any_req = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    tx_data_d   = tx_data_q;
    ack_d       = '0;
    done_d      = '0;
    tx_load_d   = 1'b0;
    tx_enable_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = LOAD;
          g_d         = win;
          tx_data_d   = bus.req_data[int'(win)*8 +: 8];
          ack_d[win]  = 1'b1;
          cnt_d       = CW'(LOAD_CYCLES - 1);
          tx_load_d   = 1'b1;
          tx_enable_d = 1'b1;
        end else begin
          tx_data_d = '0;
        end
      end
      LOAD: begin
        tx_enable_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = WAIT;
        end else begin
          tx_load_d = 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        tx_enable_d = 1'b1;
        if (sent_edge) begin
          tx_enable_d = 1'b0;
          done_d[g_q] = 1'b1;
          ptr_d       = next_g;
          state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
          cnt_d       = CW'(GAPLD);
        end
`ifdef TX_TIMEOUT_EN
        // cnt arrives here at zero from LOAD and counts elapsed WAIT cycles.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tx_enable_d = 1'b0;
          timeout_d   = 1'b1;
          ptr_d       = next_g;
          state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
          cnt_d       = CW'(GAPLD);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      GAP: begin
        tx_data_d = '0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      g_q         <= '0;
      tx_data_q   <= '0;
      ack_q       <= '0;
      done_q      <= '0;
      tx_load_q   <= 1'b0;
      tx_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      tx_sent_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      tx_data_q   <= tx_data_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      tx_load_q   <= tx_load_d;
      tx_enable_q <= tx_enable_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      tx_sent_q   <= bus.tx_sent;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.done      = done_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_load   = tx_load_q;
  assign bus.tx_enable = tx_enable_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb/tb_serial_tx_scheduler.sv - scoreboard bench for serial_tx_scheduler (N=2, LOAD=4, GAP=3, TIMEOUT=20)
module tb_serial_tx_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sent_man = 1'b0;
  logic sent_auto = 1'b0;
  logic auto_tx = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   ack_seen = 0;

  typedef struct {
    int         g;
    logic [7:0] d;
  } frame_t;

  frame_t exp_ack[$];
  frame_t exp_done[$];
  frame_t mon_e;

  serial_tx_scheduler_if #(.N(2)) bus ();
  assign bus.tx_sent = sent_man | sent_auto;

  serial_tx_scheduler #(
    .N(2), .LOAD_CYCLES(4), .GAP_CYCLES(3), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    sent_man = 1'b0;
    auto_tx = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_ack.delete();
    exp_done.delete();
  endtask

  task automatic push(input int g, input logic [7:0] d);
    frame_t f;
    f.g = g;
    f.d = d;
    exp_ack.push_back(f);
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_seen < target && n < budget) begin
      step();
      n++;
    end
    chk("ack_budget", 32'(ack_seen >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.busy || exp_ack.size() != 0 || exp_done.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("idle_budget", 32'(n < budget), 1);
  endtask

  // Scoreboard: every ack and done must match the next expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ack != '0) begin
        ack_seen++;
        if (exp_ack.size() == 0) begin
          chk("ack_unexpected", 32'(bus.ack), 0);
        end else begin
          mon_e = exp_ack.pop_front();
          chk("ack_grant", 32'(bus.ack), 32'(1) << mon_e.g);
          chk("ack_data", 32'(bus.tx_data), 32'(mon_e.d));
          exp_done.push_back(mon_e);
        end
      end
      if (bus.done != '0) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", 32'(bus.done), 0);
        end else begin
          mon_e = exp_done.pop_front();
          chk("done_grant", 32'(bus.done), 32'(1) << mon_e.g);
          chk("done_data", 32'(bus.tx_data), 32'(mon_e.d));
        end
      end
    end
  end

  // Transmitter model: char_sent rises a few cycles into WAIT, held two cycles.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (auto_tx && bus.tx_enable && !bus.tx_load) begin
        repeat (3) @(posedge clk);
        #2;
        sent_auto = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        sent_auto = 1'b0;
      end
    end
  end

  initial begin
    bus.req = '0;
    bus.req_data = '0;

    // Reset state
    do_reset();
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_tx_load", 32'(bus.tx_load), 0);
    chk("rst_tx_enable", 32'(bus.tx_enable), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);

    // Single frame latency
    bus.req_data = 16'h5A41;
    bus.req = 2'b01;
    push(0, 8'h41);
    step();
    chk("t1_ack", 32'(bus.ack), 1);
    chk("t1_tx_data", 32'(bus.tx_data), 32'h41);
    chk("t1_load_c1", 32'(bus.tx_load), 1);
    chk("t1_busy", 32'(bus.busy), 1);
    bus.req = '0;
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("t1_load_hold", 32'(bus.tx_load), 1);
    end
    step();
    chk("t1_load_c5", 32'(bus.tx_load), 0);
    chk("t1_enable_c5", 32'(bus.tx_enable), 1);
    repeat (5) step();
    chk("t1_no_done_c10", 32'(bus.done), 0);
    sent_man = 1'b1;
    step();
    chk("t1_done_c11", 32'(bus.done), 1);
    chk("t1_enable_c11", 32'(bus.tx_enable), 0);
    chk("t1_timeout_c11", 32'(bus.timeout), 0);
    sent_man = 1'b0;
    step();
    chk("t1_busy_c12", 32'(bus.busy), 1);
    step();
    chk("t1_busy_c13", 32'(bus.busy), 1);
    step();
    chk("t1_busy_c14", 32'(bus.busy), 0);

    // Round-robin with both requesters held high
    do_reset();
    auto_tx = 1'b1;
    bus.req_data = 16'h5A41;
    bus.req = 2'b11;
    push(0, 8'h41);
    push(1, 8'h5A);
    push(0, 8'h41);
    push(1, 8'h5A);
    wait_acks(ack_seen + 4, 200);
    bus.req = '0;
    wait_idle(100);

    // Stale tx_sent high on WAIT entry is ignored
    do_reset();
    sent_man = 1'b1;
    step();
    step();
    bus.req_data = 16'h0033;
    bus.req = 2'b01;
    push(0, 8'h33);
    step();
    bus.req = '0;
    repeat (4) step();
    for (int c = 0; c < 6; c++) begin
      chk("t3_stale_done", 32'(bus.done), 0);
      chk("t3_stale_enable", 32'(bus.tx_enable), 1);
      step();
    end
    sent_man = 1'b0;
    step();
    step();
    sent_man = 1'b1;
    step();
    chk("t3_done_after_edge", 32'(bus.done), 1);
    sent_man = 1'b0;
    wait_idle(50);

    // Reset during LOAD; ptr (1 here) must return to 0
    bus.req_data = 16'h0022;
    bus.req = 2'b01;
    push(0, 8'h22);
    step();
    bus.req = '0;
    step();
    rst = 1'b1;
    step();
    chk("t4_load", 32'(bus.tx_load), 0);
    chk("t4_enable", 32'(bus.tx_enable), 0);
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_done", 32'(bus.done), 0);
    rst = 1'b0;
    exp_done.delete();
    auto_tx = 1'b1;
    bus.req_data = 16'h5A41;
    bus.req = 2'b11;
    push(0, 8'h41);
    push(1, 8'h5A);
    push(1, 8'h5A);
    wait_acks(ack_seen + 1, 50);
    bus.req = 2'b10;
    wait_acks(ack_seen + 2, 100);
    bus.req = '0;
    wait_idle(100);

    // req_data change after ack does not reach tx_data
    bus.req_data = 16'h0041;
    bus.req = 2'b01;
    push(0, 8'h41);
    step();
    bus.req_data = 16'h00FF;
    bus.req = '0;
    for (int c = 0; c < 40; c++) begin
      step();
      chk("t5_tx_data_hold", 32'(bus.tx_data), 32'h41);
      if (bus.done != '0) break;
    end
    wait_idle(50);

`ifdef TX_TIMEOUT_EN
    // Watchdog abort, then the pending requester is served
    do_reset();
    bus.req_data = 16'h5A41;
    bus.req = 2'b11;
    push(0, 8'h41);
    push(1, 8'h5A);
    step();
    bus.req = 2'b10;
    repeat (4) step();
    chk("t6_wait_enable", 32'(bus.tx_enable), 1);
    for (int c = 0; c < 20; c++) begin
      chk("t6_no_timeout_yet", 32'(bus.timeout), 0);
      step();
    end
    chk("t6_timeout", 32'(bus.timeout), 1);
    chk("t6_no_done", 32'(bus.done), 0);
    chk("t6_enable_off", 32'(bus.tx_enable), 0);
    if (exp_done.size() != 0) void'(exp_done.pop_front());
    repeat (4) step();
    chk("t6_next_grant", 32'(bus.ack), 2);
    bus.req = '0;
    auto_tx = 1'b1;
    wait_idle(50);
`endif

    chk("final_ack_queue", 32'(exp_ack.size()), 0);
    chk("final_done_queue", 32'(exp_done.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
